forward_select_ctrl: RTL and testbench

- Pipeline forwarding and hazard controller for the 5-stage datapath.
- Keeps its own shadow copy of destination-register information for the EX, MEM, WB and post-WB stages.
- Generates the 2-bit select codes that drive the EX-stage 4:1 operand muxes (Mux32bits4to1, Src input) for ALU operands A and B.
- Also generates the load-use stall and bubble control.

---
 rtl/forward_select_ctrl_pkg.sv | 28 ++
 rtl/forward_select_ctrl_fwd_match.sv | 24 ++
 rtl/forward_select_ctrl.sv | 64 ++++++
 tb/tb_forward_select_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/forward_select_ctrl_pkg.sv
// forward_select_ctrl_pkg: select encodings and pipeline slot records for the forwarding controller
package forward_select_ctrl_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    // Slots store specifiers zero-extended to this width so REG_ADDR_W may vary up to it
    localparam int SLOT_ADDR_W = 8;
    typedef enum logic [1:0] {
        SEL_RF    = 2'd0,
        SEL_EXMEM = 2'd1,
        SEL_MEMWB = 2'd2,
        SEL_WB2   = 2'd3
    } fwd_sel_e;
    typedef logic [SLOT_ADDR_W-1:0] reg_addr_t;
    typedef struct packed {
        logic      valid;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      rs_used;
        logic      rt_used;
        reg_addr_t dest;
        logic      reg_write;
        logic      mem_read;
    } ex_slot_t;
    typedef struct packed {
        logic      valid;
        reg_addr_t dest;
        logic      reg_write;
    } dn_slot_t;
endpackage

// File: rtl/forward_select_ctrl_fwd_match.sv
// fwd_match: priority select for one EX operand against the MEM, WB and WB2 slots
module fwd_match
    import forward_select_ctrl_pkg::*;
#(
    parameter bit WB2_EN = 1'b1
) (
    input  logic                        used,
    input  reg_addr_t                   src,
    input  logic [2:0]                  valid,
    input  logic [2:0]                  reg_write,
    input  logic [2:0][SLOT_ADDR_W-1:0] dest,
    output fwd_sel_e                    sel
);
    logic [2:0] hit;
    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) hit[i] = valid[i] & reg_write[i] & (dest[i] == src);
    end
    // Index 0 is the newest writer, so it wins
    assign sel = (!used || src == '0) ? SEL_RF :
                 hit[0] ? SEL_EXMEM :
                 hit[1] ? SEL_MEMWB :
                 (WB2_EN && hit[2]) ? SEL_WB2 : SEL_RF;
endmodule

// File: rtl/forward_select_ctrl.sv
// forward_select_ctrl: EX operand forwarding selects and load-use stall for the 5-stage pipeline
module forward_select_ctrl
    import forward_select_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter bit WB2_BYPASS_EN = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic                  IdRsUsed,
    input  logic                  IdRtUsed,
    input  logic [REG_ADDR_W-1:0] IdDest,
    input  logic                  IdRegWrite,
    input  logic                  IdMemRead,
    input  logic                  Flush,
    output logic [1:0]            FwdSrcA,
    output logic [1:0]            FwdSrcB,
    output logic                  Stall
);
    ex_slot_t  ex;
    dn_slot_t  mem, wb, wb2;
    reg_addr_t id_rs, id_rt, id_dest;
    fwd_sel_e  sel_a, sel_b;
    assign id_rs   = reg_addr_t'(IdRs);
    assign id_rt   = reg_addr_t'(IdRt);
    assign id_dest = reg_addr_t'(IdDest);
    assign Stall = ex.valid & ex.mem_read & ex.reg_write & (ex.dest != '0) &
                   ((IdRsUsed & (id_rs == ex.dest)) | (IdRtUsed & (id_rt == ex.dest)));
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
            wb2 <= '0;
        end else begin
            wb2 <= wb;
            wb  <= mem;
            mem <= dn_slot_t'{valid: ex.valid, dest: ex.dest, reg_write: ex.reg_write};
            ex  <= (Stall || Flush) ? ex_slot_t'('0) :
                   ex_slot_t'{valid: 1'b1, rs: id_rs, rt: id_rt, rs_used: IdRsUsed, rt_used: IdRtUsed,
                              dest: id_dest, reg_write: IdRegWrite, mem_read: IdMemRead};
        end
    end
    fwd_match #(.WB2_EN(WB2_BYPASS_EN)) u_match_a (
        .used      (ex.valid & ex.rs_used),
        .src       (ex.rs),
        .valid     ({wb2.valid, wb.valid, mem.valid}),
        .reg_write ({wb2.reg_write, wb.reg_write, mem.reg_write}),
        .dest      ({wb2.dest, wb.dest, mem.dest}),
        .sel       (sel_a)
    );
    fwd_match #(.WB2_EN(WB2_BYPASS_EN)) u_match_b (
        .used      (ex.valid & ex.rt_used),
        .src       (ex.rt),
        .valid     ({wb2.valid, wb.valid, mem.valid}),
        .reg_write ({wb2.reg_write, wb.reg_write, mem.reg_write}),
        .dest      ({wb2.dest, wb.dest, mem.dest}),
        .sel       (sel_b)
    );
    assign FwdSrcA = sel_a;
    assign FwdSrcB = sel_b;
endmodule

// File: tb/tb_forward_select_ctrl.sv
// tb_forward_select_ctrl: directed forwarding/stall scenarios checked against a select scoreboard
module tb_forward_select_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_rs_used, id_rt_used, id_reg_write, id_mem_read, flush;
    logic [1:0] fwd_a, fwd_b, fwd_a0, fwd_b0;
    logic       stall, stall0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] b0;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    forward_select_ctrl #(.REG_ADDR_W(5), .WB2_BYPASS_EN(1'b1)) dut (
        .Clk(clk), .Rst(rst), .IdRs(id_rs), .IdRt(id_rt), .IdRsUsed(id_rs_used), .IdRtUsed(id_rt_used),
        .IdDest(id_dest), .IdRegWrite(id_reg_write), .IdMemRead(id_mem_read), .Flush(flush),
        .FwdSrcA(fwd_a), .FwdSrcB(fwd_b), .Stall(stall)
    );
    forward_select_ctrl #(.REG_ADDR_W(5), .WB2_BYPASS_EN(1'b0)) dut_nb (
        .Clk(clk), .Rst(rst), .IdRs(id_rs), .IdRt(id_rt), .IdRsUsed(id_rs_used), .IdRtUsed(id_rt_used),
        .IdDest(id_dest), .IdRegWrite(id_reg_write), .IdMemRead(id_mem_read), .Flush(flush),
        .FwdSrcA(fwd_a0), .FwdSrcB(fwd_b0), .Stall(stall0)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed A=%0d B=%0d", tag, fwd_a, fwd_b);
        end else begin
            e = q.pop_front();
            chk({tag, "_a"}, fwd_a, e.a);
            chk({tag, "_b"}, fwd_b, e.b);
            chk({tag, "_b_nobypass"}, fwd_b0, e.b0);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rsu, input logic rtu,
                         input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
        id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    // Present one ID instruction; ea/eb/eb0 are its selects once it reaches EX
    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic [4:0] dest, input logic rw, input logic mr,
                        input logic fl, input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] eb0,
                        input logic st);
        exp_t e;
        drive(rs, rt, rsu, rtu, dest, rw, mr, fl);
        #1;
        chk({tag, "_stall"}, {1'b0, stall}, {1'b0, st});
        chk({tag, "_stall_nobypass"}, {1'b0, stall0}, {1'b0, st});
        pop_check(tag);
        e.a  = (st || fl) ? 2'd0 : ea;
        e.b  = (st || fl) ? 2'd0 : eb;
        e.b0 = (st || fl) ? 2'd0 : eb0;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step("nop", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_a", fwd_a, 2'd0);
        chk("reset_b", fwd_b, 2'd0);
        chk("reset_stall", {1'b0, stall}, 2'd0);
        rst = 1'b0;
        e.a = 2'd0; e.b = 2'd0; e.b0 = 2'd0;
        q.push_back(e);

        step("b2b_wr",   5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("b2b_rd",   5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);
        nops(3);

        step("d2_wr",    5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        nops(1);
        step("d2_rd",    5'd6, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 1'b0);
        nops(3);

        step("d3_wr",    5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        nops(2);
        step("d3_rd",    5'd6, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0);
        nops(3);

        step("dbl_w1",   5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("dbl_w2",   5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("dbl_rd",   5'd7, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);
        nops(3);

        step("lu_lw",    5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("lu_stall", 5'd8, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        step("lu_rd",    5'd8, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
        nops(3);

        step("fl_lw",    5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
        step("fl_rd",    5'd8, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        nops(3);

        step("z_wr",     5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("z_rd",     5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        nops(3);

        step("rst_wr",   5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("rst_rd",   5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        pop_check("pre_rst");
        rst = 1'b1;
        #1;
        chk("async_rst_a", fwd_a, 2'd0);
        chk("async_rst_b", fwd_b, 2'd0);
        chk("async_rst_stall", {1'b0, stall}, 2'd0);
        q.delete();
        #1;
        rst = 1'b0;
        e.a = 2'd0; e.b = 2'd0; e.b0 = 2'd0;
        q.push_back(e);
        @(posedge clk);
        #2;
        step("post_rst", 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        nops(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
